// File: rtl/sprite_pkg.sv
// Shared definitions for the Fireboy sprite animator.
//   pose_t      : animation pose selected from the motion direction code
//   FRAME_WORDS : words per 60x60 frame in the sprite-sheet ROM
//   POSE_LEN    : number of frames in each pose's animation loop
//   POSE_FIRST  : sheet frame index of each pose's first frame
//   FRAME_BASE  : ROM base address of each of the 12 sheet frames
//   decode_pose : direction code (0..15) to pose
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN_R = 3'd1,
        RUN_L = 3'd2,
        JUMP  = 3'd3,
        FALL  = 3'd4
    } pose_t;

    localparam int unsigned FRAME_WORDS = 3600;
    localparam int unsigned NUM_FRAMES  = 12;
    localparam int unsigned NUM_POSES   = 5;

    // Indexed by pose_t encoding.
    localparam logic [3:0] POSE_LEN [NUM_POSES] = '{4'd2, 4'd4, 4'd4, 4'd1, 4'd1};
    localparam logic [3:0] POSE_FIRST [NUM_POSES] = '{4'd0, 4'd2, 4'd6, 4'd10, 4'd11};

    localparam logic [15:0] FRAME_BASE [NUM_FRAMES] = '{
        16'd0,     16'd3600,  16'd7200,  16'd10800,
        16'd14400, 16'd18000, 16'd21600, 16'd25200,
        16'd28800, 16'd32400, 16'd36000, 16'd39600
    };

    // Codes 9..15 are not produced by the motion block; treat them as standing still.
    function automatic pose_t decode_pose(input logic [3:0] dir);
        pose_t p;
        case (dir)
            4'd0, 4'd1, 4'd2: p = JUMP;
            4'd3:             p = RUN_L;
            4'd5:             p = RUN_R;
            4'd6, 4'd7, 4'd8: p = FALL;
            default:          p = IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/anim_sequencer.sv
// Animation sequencer: detects frame_clk rising edges, tracks the current pose and
// steps through that pose's frames every ANIM_DIV frame edges.
// Ports:
//   Clk, Reset  : system clock, synchronous active-high reset
//   frame_clk   : vertical-sync rate clock, sampled as data and edge-detected
//   direction   : 4-bit motion code from the motion block
//   pose        : current pose register
//   frame_idx   : sprite-sheet frame index (0..11) for the current pose/sub-frame
module anim_sequencer
    import sprite_pkg::*;
#(
    parameter int unsigned ANIM_DIV = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [3:0]  direction,
    output pose_t       pose,
    output logic [3:0]  frame_idx
);

    localparam int unsigned TICK_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic              fc_curr_q, fc_prev_q;
    logic              frame_edge;
    pose_t             dec_pose;
    pose_t             cur_pose_q, cur_pose_d;
    logic [3:0]        sub_frame_q, sub_frame_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

    assign frame_edge = fc_curr_q & ~fc_prev_q;

    always_comb begin
        dec_pose    = decode_pose(direction);
        cur_pose_d  = cur_pose_q;
        sub_frame_d = sub_frame_q;
        tick_cnt_d  = tick_cnt_q;
        if (dec_pose != cur_pose_q) begin
            // Pose change restarts the loop; a coincident frame edge is dropped.
            cur_pose_d  = dec_pose;
            sub_frame_d = 4'd0;
            tick_cnt_d  = '0;
        end else if (frame_edge) begin
            if (tick_cnt_q == TICK_W'(ANIM_DIV - 1)) begin
                tick_cnt_d = '0;
                if (sub_frame_q == POSE_LEN[cur_pose_q] - 4'd1) begin
                    sub_frame_d = 4'd0;
                end else begin
                    sub_frame_d = sub_frame_q + 4'd1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_curr_q   <= 1'b0;
            fc_prev_q   <= 1'b0;
            cur_pose_q  <= IDLE;
            sub_frame_q <= 4'd0;
            tick_cnt_q  <= '0;
        end else begin
            fc_curr_q   <= frame_clk;
            fc_prev_q   <= fc_curr_q;
            cur_pose_q  <= cur_pose_d;
            sub_frame_q <= sub_frame_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign pose      = cur_pose_q;
    assign frame_idx = POSE_FIRST[cur_pose_q] + sub_frame_q;

endmodule

// File: rtl/fireboy_sprite_animator.sv
// Fireboy sprite animator: turns the motion block's hit flag, sprite-local address and
// direction into a sprite-sheet ROM address and a masked palette index, with DrawX/DrawY
// delayed to line up with the ROM read. Fixed 3-cycle latency, no stalls.
// Ports:
//   Clk, Reset           : system clock, synchronous active-high reset
//   frame_clk            : frame-rate clock, drives animation timing
//   is_Fireboy           : current pixel lies inside the Fireboy box
//   Fireboy_address      : sprite-local pixel address (0..3599)
//   Fireboy_direction    : motion code 0..8
//   DrawX, DrawY         : current pixel coordinates
//   rom_addr / rom_data  : external synchronous sprite-sheet ROM (1-cycle read)
//   sprite_on            : opaque Fireboy pixel at DrawX_out/DrawY_out
//   sprite_index         : palette index, 0 when sprite_on is low
//   DrawX_out, DrawY_out : coordinates delayed 3 cycles
//   pose                 : current pose (debug)
module fireboy_sprite_animator
    import sprite_pkg::*;
#(
    parameter int unsigned ANIM_DIV    = 6,
    parameter int unsigned PIX_W       = 4,
    parameter int unsigned TRANSPARENT = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             is_Fireboy,
    input  logic [11:0]      Fireboy_address,
    input  logic [3:0]       Fireboy_direction,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic [15:0]      rom_addr,
    input  logic [PIX_W-1:0] rom_data,
    output logic             sprite_on,
    output logic [PIX_W-1:0] sprite_index,
    output logic [9:0]       DrawX_out,
    output logic [9:0]       DrawY_out,
    output logic [2:0]       pose
);

    pose_t      seq_pose;
    logic [3:0] frame_idx;

    anim_sequencer #(
        .ANIM_DIV (ANIM_DIV)
    ) u_seq (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .direction (Fireboy_direction),
        .pose      (seq_pose),
        .frame_idx (frame_idx)
    );

    assign pose = seq_pose;

    // Stage 1 travels alongside rom_addr, stage 2 alongside rom_data.
    logic       v1_q, v2_q;
    logic [9:0] x1_q, y1_q, x2_q, y2_q;
    logic       sprite_on_next;

    always_comb begin
        sprite_on_next = v2_q & (rom_data != PIX_W'(TRANSPARENT));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_q         <= 1'b0;
            x1_q         <= 10'd0;
            y1_q         <= 10'd0;
            rom_addr     <= 16'd0;
            v2_q         <= 1'b0;
            x2_q         <= 10'd0;
            y2_q         <= 10'd0;
            sprite_on    <= 1'b0;
            sprite_index <= '0;
            DrawX_out    <= 10'd0;
            DrawY_out    <= 10'd0;
        end else begin
            v1_q         <= is_Fireboy;
            x1_q         <= DrawX;
            y1_q         <= DrawY;
            // Computed every cycle so the ROM read is never gated by is_Fireboy.
            rom_addr     <= FRAME_BASE[frame_idx] + {4'b0000, Fireboy_address};
            v2_q         <= v1_q;
            x2_q         <= x1_q;
            y2_q         <= y1_q;
            sprite_on    <= sprite_on_next;
            sprite_index <= sprite_on_next ? rom_data : '0;
            DrawX_out    <= x2_q;
            DrawY_out    <= y2_q;
        end
    end

endmodule

// File: tb/tb_fireboy_sprite_animator.sv
// Self-checking bench for fireboy_sprite_animator with a behavioural ROM and reference model.
module tb_fireboy_sprite_animator;

    localparam int ANIM_DIV = 6;
    localparam int WORDS    = 3600;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        is_Fireboy = 1'b0;
    logic [11:0] Fireboy_address = 12'd0;
    logic [3:0]  Fireboy_direction = 4'd4;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic        sprite_on;
    logic [3:0]  sprite_index;
    logic [9:0]  DrawX_out;
    logic [9:0]  DrawY_out;
    logic [2:0]  pose;

    logic        rom_force = 1'b0;
    logic [3:0]  rom_force_val = 4'd0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pose held, frame edges seen since entering it, address driven.
    int m_pose  = 0;
    int m_edges = 0;
    int m_addr  = 0;

    fireboy_sprite_animator #(
        .ANIM_DIV    (ANIM_DIV),
        .PIX_W       (4),
        .TRANSPARENT (0)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .frame_clk         (frame_clk),
        .is_Fireboy        (is_Fireboy),
        .Fireboy_address   (Fireboy_address),
        .Fireboy_direction (Fireboy_direction),
        .DrawX             (DrawX),
        .DrawY             (DrawY),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .sprite_on         (sprite_on),
        .sprite_index      (sprite_index),
        .DrawX_out         (DrawX_out),
        .DrawY_out         (DrawY_out),
        .pose              (pose)
    );

    always #10 Clk = ~Clk;

    // Sheet contents: roughly a quarter of the words are transparent.
    function automatic logic [3:0] rom_fn(input logic [15:0] a);
        if (a[1:0] == 2'b00) return 4'd0;
        return a[5:2] ^ a[9:6] ^ 4'd1;
    endfunction

    always @(posedge Clk) rom_data <= rom_force ? rom_force_val : rom_fn(rom_addr);

    function automatic int pose_of(input int d);
        if (d == 4) return 0;
        if (d == 5) return 1;
        if (d == 3) return 2;
        if (d <= 2) return 3;
        if (d <= 8) return 4;
        return 0;
    endfunction

    function automatic int first_of(input int p);
        case (p)
            1:       return 2;
            2:       return 6;
            3:       return 10;
            4:       return 11;
            default: return 0;
        endcase
    endfunction

    function automatic int len_of(input int p);
        case (p)
            1, 2:    return 4;
            3, 4:    return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int exp_base();
        return (first_of(m_pose) + (m_edges / ANIM_DIV) % len_of(m_pose)) * WORDS;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(exp_base() + m_addr));
        chk({tag, "_pose"}, 32'(pose), 32'(m_pose));
    endtask

    // One full frame_clk pulse; the sequencer consumes the edge on the second tick.
    task automatic frame_pulse(input bit counted);
        frame_clk = 1'b1;
        tick();
        tick();
        frame_clk = 1'b0;
        tick();
        tick();
        if (counted) m_edges++;
    endtask

    task automatic set_dir(input int d);
        Fireboy_direction = 4'(d);
        tick();
        tick();
        if (pose_of(d) != m_pose) begin
            m_pose  = pose_of(d);
            m_edges = 0;
        end
    endtask

    task automatic set_addr(input int a);
        Fireboy_address = 12'(a);
        m_addr = a;
        tick();
    endtask

    // Random pixel stream with the pose held; outputs lag inputs by two sampling ticks here.
    task automatic run_pixels(input int cnt);
        logic [3:0] dat;
        logic       e_on[$];
        logic [3:0] e_idx[$];
        logic [9:0] e_x[$];
        logic [9:0] e_y[$];
        for (int i = 0; i < cnt + 2; i++) begin
            if (i < cnt) begin
                is_Fireboy      = 1'($urandom_range(0, 1));
                Fireboy_address = 12'($urandom_range(0, WORDS - 1));
                DrawX           = 10'($urandom_range(0, 639));
                DrawY           = 10'($urandom_range(0, 479));
                m_addr          = int'(Fireboy_address);
                dat             = rom_fn(16'(exp_base() + m_addr));
                e_on.push_back(is_Fireboy && dat != 4'd0);
                e_idx.push_back((is_Fireboy && dat != 4'd0) ? dat : 4'd0);
                e_x.push_back(DrawX);
                e_y.push_back(DrawY);
            end
            tick();
            if (i < cnt) chk("px_rom_addr", 32'(rom_addr), 32'(exp_base() + m_addr));
            if (i >= 2) begin
                chk("px_sprite_on", 32'(sprite_on), 32'(e_on.pop_front()));
                chk("px_sprite_index", 32'(sprite_index), 32'(e_idx.pop_front()));
                chk("px_drawx", 32'(DrawX_out), 32'(e_x.pop_front()));
                chk("px_drawy", 32'(DrawY_out), 32'(e_y.pop_front()));
            end
        end
        is_Fireboy = 1'b0;
    endtask

    task automatic forced_pixel(input logic [3:0] val, input string tag);
        rom_force_val   = val;
        rom_force       = 1'b1;
        is_Fireboy      = 1'b1;
        DrawX           = 10'd123;
        DrawY           = 10'd45;
        tick();
        tick();
        tick();
        chk({tag, "_on"}, 32'(sprite_on), 32'(val != 4'd0));
        chk({tag, "_idx"}, 32'(sprite_index), 32'(val));
        chk({tag, "_x"}, 32'(DrawX_out), 32'd123);
        chk({tag, "_y"}, 32'(DrawY_out), 32'd45);
        is_Fireboy = 1'b0;
        rom_force  = 1'b0;
    endtask

    initial begin
        // Reset state.
        Reset = 1'b1;
        Fireboy_direction = 4'd4;
        Fireboy_address = 12'd100;
        m_addr = 100;
        repeat (3) tick();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_sprite_on", 32'(sprite_on), 32'd0);
        chk("rst_sprite_index", 32'(sprite_index), 32'd0);
        chk("rst_drawx", 32'(DrawX_out), 32'd0);
        chk("rst_drawy", 32'(DrawY_out), 32'd0);
        chk("rst_pose", 32'(pose), 32'd0);
        Reset = 1'b0;
        tick();
        chk("rel_rom_addr", 32'(rom_addr), 32'd100);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("rel_sprite_on", 32'(sprite_on), 32'd0);
            chk("rel_sprite_index", 32'(sprite_index), 32'd0);
            chk("rel_pose", 32'(pose), 32'd0);
        end

        // RUN_R loop through 24 edges, wrapping back to frame 2.
        set_addr(0);
        set_dir(5);
        chk_addr("runr_start");
        for (int i = 0; i < 24; i++) begin
            frame_pulse(1'b1);
            chk_addr("runr_step");
        end

        // Reach sub-frame 2 with the tick counter one short of stepping.
        for (int i = 0; i < 17; i++) frame_pulse(1'b1);
        chk_addr("runr_sub2");
        // Switch to RUN_L on the cycle the edge is presented; the edge is lost.
        frame_clk = 1'b1;
        tick();
        Fireboy_direction = 4'd3;
        tick();
        frame_clk = 1'b0;
        m_pose = 2;
        m_edges = 0;
        tick();
        chk_addr("switch_runl");
        for (int i = 0; i < 6; i++) begin
            frame_pulse(1'b1);
            chk_addr("runl_step");
        end

        // Reset while RUN_L at sub-frame 3.
        set_addr(77);
        for (int i = 0; i < 12; i++) frame_pulse(1'b1);
        chk_addr("runl_sub3");
        Reset = 1'b1;
        tick();
        chk("rstmid_pose", 32'(pose), 32'd0);
        Fireboy_direction = 4'd4;
        frame_pulse(1'b0);
        frame_pulse(1'b0);
        chk("rstmid_rom_addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;
        m_pose = 0;
        m_edges = 0;
        tick();
        chk_addr("rstmid_rel");
        for (int i = 0; i < 6; i++) begin
            frame_pulse(1'b1);
            chk_addr("idle_step");
        end

        // Pose re-decoded on the first cycle after release.
        Reset = 1'b1;
        Fireboy_direction = 4'd5;
        tick();
        tick();
        Reset = 1'b0;
        tick();
        chk("redecode_pose", 32'(pose), 32'd1);
        chk("redecode_first_addr", 32'(rom_addr), 32'(m_addr));
        m_pose = 1;
        m_edges = 0;
        tick();
        chk_addr("redecode");

        // Pose base addresses, including an out-of-range code.
        set_addr(1234);
        set_dir(1);
        chk_addr("jump");
        set_dir(7);
        chk_addr("fall");
        for (int i = 0; i < 7; i++) frame_pulse(1'b1);
        chk_addr("fall_single");
        set_dir(12);
        chk_addr("code12");

        // Transparency masking with forced ROM data.
        forced_pixel(4'h0, "transparent");
        forced_pixel(4'hA, "opaque");

        // Randomized mix of direction changes, frame edges, address changes and pixel runs.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: set_dir(int'($urandom_range(0, 15)));
                1: begin
                    int k = int'($urandom_range(1, 8));
                    for (int j = 0; j < k; j++) frame_pulse(1'b1);
                end
                2: set_addr(int'($urandom_range(0, WORDS - 1)));
                default: run_pixels(int'($urandom_range(3, 10)));
            endcase
            chk_addr("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
